// File: rtl/dout_unpacker.sv
// dout_unpacker
//   Splits a 256-bit result word into N_LANES lanes of LANE_W bits and
//   emits them lane 0 first, one lane per output transfer. A single
//   holding register buffers the word. The next word may load on the same
//   edge as the last-lane transfer, so sustained throughput has no bubble.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   din_vld    upstream word valid
//   din_busy   upstream backpressure (high while a word is still draining)
//   din_data   upstream 256-bit word
//   dout_vld   lane valid
//   dout_busy  downstream backpressure
//   dout_data  current lane
//   dout_last  presented lane is lane N_LANES-1
//   word_cnt   number of fully emitted words, wraps at 16 bits
module dout_unpacker #(
    parameter int LANE_W  = 32,
    parameter int N_LANES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    output logic              din_busy,
    input  logic [255:0]      din_data,
    output logic              dout_vld,
    input  logic              dout_busy,
    output logic [LANE_W-1:0] dout_data,
    output logic              dout_last,
    output logic [15:0]       word_cnt
);

    // Keep the index at least one bit wide so N_LANES=1 still elaborates.
    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                          state_q;
    logic [N_LANES-1:0][LANE_W-1:0]  hold_q;
    logic [IDX_W-1:0]                lane_idx_q;
    logic [15:0]                     word_cnt_q;

    logic full;
    logic on_last;
    logic out_xfer;
    logic last_xfer;
    logic in_xfer;

    assign full      = (state_q == SHIFT);
    assign on_last   = full && (lane_idx_q == LAST_IDX);
    assign out_xfer  = full && !dout_busy;
    assign last_xfer = out_xfer && on_last;

    // Upstream may only refill on the edge that retires the last lane.
    assign din_busy  = full && !last_xfer;
    assign in_xfer   = din_vld && !din_busy;

    assign dout_vld  = full;
    assign dout_last = on_last;
    assign dout_data = hold_q[lane_idx_q];
    assign word_cnt  = word_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            lane_idx_q <= '0;
        end else if (in_xfer) begin
            // Covers both a fresh load from EMPTY and the bubble-free
            // refill coinciding with the last-lane transfer.
            state_q    <= SHIFT;
            hold_q     <= din_data;
            lane_idx_q <= '0;
        end else if (last_xfer) begin
            state_q    <= EMPTY;
            lane_idx_q <= '0;
        end else if (out_xfer) begin
            lane_idx_q <= lane_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= '0;
        end else if (last_xfer) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_dout_unpacker.sv
// tb_dout_unpacker
//   Directed checks of reset, single word, back-to-back, backpressure and
//   mid-word reset on the default 8x32 configuration; word counter wrap on
//   a 1x256 instance (one word per cycle); then a random scoreboard run.
module tb_dout_unpacker;

    logic         clk;
    logic         rst;
    logic         din_vld;
    logic         din_busy;
    logic [255:0] din_data;
    logic         dout_vld;
    logic         dout_busy;
    logic [31:0]  dout_data;
    logic         dout_last;
    logic [15:0]  word_cnt;

    logic         w_din_vld;
    logic         w_din_busy;
    logic [255:0] w_din_data;
    logic         w_dout_vld;
    logic         w_dout_busy;
    logic [255:0] w_dout_data;
    logic         w_dout_last;
    logic [15:0]  w_word_cnt;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } lane_t;

    lane_t sb_q[$];

    dout_unpacker #(.LANE_W(32), .N_LANES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_vld   (din_vld),
        .din_busy  (din_busy),
        .din_data  (din_data),
        .dout_vld  (dout_vld),
        .dout_busy (dout_busy),
        .dout_data (dout_data),
        .dout_last (dout_last),
        .word_cnt  (word_cnt)
    );

    dout_unpacker #(.LANE_W(256), .N_LANES(1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .din_vld   (w_din_vld),
        .din_busy  (w_din_busy),
        .din_data  (w_din_data),
        .dout_vld  (w_dout_vld),
        .dout_busy (w_dout_busy),
        .dout_data (w_dout_data),
        .dout_last (w_dout_last),
        .word_cnt  (w_word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [31:0] base, input logic [31:0] inc);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = base + inc * i;
        return w;
    endfunction

    initial begin
        logic [255:0] wa, wb, wc, we, wf;
        bit           in_x, out_x;
        lane_t        exp_l;

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        din_vld   = 1'b0;
        din_data  = '0;
        dout_busy = 1'b0;
        w_din_vld   = 1'b0;
        w_din_data  = {8{32'h5A5AC3C3}};
        w_dout_busy = 1'b0;

        // Reset state
        #3;
        chk("rst_din_busy",  din_busy,  1'b0);
        chk("rst_dout_vld",  dout_vld,  1'b0);
        chk("rst_dout_data", dout_data, 32'h0);
        chk("rst_dout_last", dout_last, 1'b0);
        chk("rst_word_cnt",  word_cnt,  16'h0);
        step();
        rst = 1'b1;
        step();

        // Single word, lane i = 0x11111111*i
        din_data = mk(32'h0, 32'h11111111);
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_vld",  dout_vld,  1'b1);
            chk("single_data", dout_data, 32'h11111111 * i);
            chk("single_last", dout_last, (i == 7));
            step();
        end
        chk("single_idle_vld", dout_vld, 1'b0);
        chk("single_word_cnt", word_cnt, 16'd1);

        // Back-to-back, din_vld held high; B loads on A's last-lane edge
        wa = mk(32'hA0000000, 32'h1);
        wb = mk(32'hB0000000, 32'h1);
        din_data = wa;
        din_vld  = 1'b1;
        step();
        din_data = wb;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_vld",  dout_vld, 1'b1);
            chk("b2b_data", dout_data, (i < 8) ? wa[32*i +: 32] : wb[32*(i-8) +: 32]);
            chk("b2b_busy", din_busy, (i % 8) != 7);
            if (i == 8) din_vld = 1'b0;
            step();
        end
        chk("b2b_idle_vld", dout_vld, 1'b0);
        chk("b2b_word_cnt", word_cnt, 16'd3);

        // Backpressure on lane 3 for 5 cycles; upstream pushes junk meanwhile
        wc = mk(32'hC0000000, 32'h10);
        din_data = wc;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_pre_data", dout_data, wc[32*i +: 32]);
            step();
        end
        dout_busy = 1'b1;
        din_vld   = 1'b1;
        din_data  = ~wc;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_hold_data", dout_data, wc[32*3 +: 32]);
            chk("bp_hold_busy", din_busy, 1'b1);
            chk("bp_hold_last", dout_last, 1'b0);
            step();
        end
        dout_busy = 1'b0;
        din_vld   = 1'b0;
        for (int i = 3; i < 8; i++) begin
            chk("bp_post_data", dout_data, wc[32*i +: 32]);
            chk("bp_post_last", dout_last, (i == 7));
            step();
        end
        chk("bp_idle_vld", dout_vld, 1'b0);
        chk("bp_word_cnt", word_cnt, 16'd4);

        // Reset during lane 5
        we = mk(32'hE0000000, 32'h3);
        wf = mk(32'hF0000000, 32'h7);
        din_data = we;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        repeat (5) step();
        chk("rmw_lane5", dout_data, we[32*5 +: 32]);
        rst = 1'b0;
        #1;
        chk("rmw_vld",      dout_vld,  1'b0);
        chk("rmw_word_cnt", word_cnt,  16'd0);
        chk("rmw_data",     dout_data, 32'h0);
        din_data = wf;
        din_vld  = 1'b1;
        step();
        chk("rmw_no_xfer_in_rst", dout_vld, 1'b0);
        #2;
        rst = 1'b1;
        step();
        din_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rmw_new_data", dout_data, wf[32*i +: 32]);
            step();
        end
        chk("rmw_new_word_cnt", word_cnt, 16'd1);

        // Random traffic against a lane scoreboard
        for (int c = 0; c < 10000; c++) begin
            din_vld   = ($urandom_range(0, 3) != 0);
            dout_busy = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 8; k++) din_data[32*k +: 32] = $urandom;
            #1;
            in_x  = din_vld && !din_busy;
            out_x = dout_vld && !dout_busy;
            if (out_x) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    exp_l = sb_q.pop_front();
                    chk("sb_data", dout_data, exp_l.data);
                    chk("sb_last", dout_last, exp_l.last);
                end
            end
            if (in_x) begin
                for (int k = 0; k < 8; k++) begin
                    exp_l.data = din_data[32*k +: 32];
                    exp_l.last = (k == 7);
                    sb_q.push_back(exp_l);
                end
            end
            step();
        end
        din_vld   = 1'b0;
        dout_busy = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (dout_vld) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    exp_l = sb_q.pop_front();
                    chk("sb_drain_data", dout_data, exp_l.data);
                    chk("sb_drain_last", dout_last, exp_l.last);
                end
            end
            step();
        end
        chk("sb_empty", sb_q.size(), 0);
        chk("sb_idle_vld", dout_vld, 1'b0);

        // Word counter wrap on the one-lane instance: one word per cycle
        chk("wrap_start", w_word_cnt, 16'h0);
        w_din_vld = 1'b1;
        step();
        repeat (65535) step();
        chk("wrap_ffff", w_word_cnt, 16'hFFFF);
        chk("wrap_busy", w_din_busy, 1'b0);
        step();
        chk("wrap_zero", w_word_cnt, 16'h0000);
        w_din_vld = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
